// File: rtl/alu_arbiter_if.sv
// Shared ALU arbiter bus: two requesters, ALU operand/result
// lines and the tagged response channel.
interface alu_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_op;
    logic             req0_l;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_op;
    logic             req1_l;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic             alu_l;
    logic [WIDTH-1:0] alu_r;
    logic             alu_z;
    logic             alu_c;
    logic             alu_s;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_z;
    logic             rsp_c;
    logic             rsp_s;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_l,
        input  req1_valid, req1_a, req1_b, req1_op, req1_l,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op, alu_l,
        input  alu_r, alu_z, alu_c, alu_s,
        output rsp_valid, rsp_id, rsp_r, rsp_z, rsp_c, rsp_s,
        input  rsp_ready
    );

    // Requesters, ALU and response consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_l,
        output req1_valid, req1_a, req1_b, req1_op, req1_l,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op, alu_l,
        output alu_r, alu_z, alu_c, alu_s,
        input  rsp_valid, rsp_id, rsp_r, rsp_z, rsp_c, rsp_s,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Registers operands, captures result/flags, returns a tagged response.
module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int FAIR  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] ops_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    // Most recently granted requester; reset to 1 so requester 0 wins first.
    logic last_id;
    logic grant;
    logic grant_id;

    // Winner selection and next-state logic
    always_comb begin
        grant     = 1'b0;
        grant_id  = 1'b0;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    grant    = 1'b1;
                    grant_id = (FAIR != 0) ? ~last_id : 1'b0;
                end else if (bus.req0_valid) begin
                    grant    = 1'b1;
                    grant_id = 1'b0;
                end else if (bus.req1_valid) begin
                    grant    = 1'b1;
                    grant_id = 1'b1;
                end
                if (grant) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req0_ready = grant & ~grant_id;
    assign bus.req1_ready = grant & grant_id;
    assign busy           = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, result capture, response handshake and op counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.alu_l     <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_r     <= '0;
            bus.rsp_z     <= 1'b0;
            bus.rsp_c     <= 1'b0;
            bus.rsp_s     <= 1'b0;
            last_id       <= 1'b1;
            ops_count     <= '0;
        end else begin
            if (grant) begin
                bus.alu_a  <= grant_id ? bus.req1_a  : bus.req0_a;
                bus.alu_b  <= grant_id ? bus.req1_b  : bus.req0_b;
                bus.alu_op <= grant_id ? bus.req1_op : bus.req0_op;
                bus.alu_l  <= grant_id ? bus.req1_l  : bus.req0_l;
                bus.rsp_id <= grant_id;
                last_id    <= grant_id;
            end
            if (state == EXEC) begin
                // Carry and sign are undefined for logic ops; force them low.
                bus.rsp_r     <= bus.alu_r;
                bus.rsp_z     <= bus.alu_z;
                bus.rsp_c     <= bus.alu_l ? 1'b0 : bus.alu_c;
                bus.rsp_s     <= bus.alu_l ? 1'b0 : bus.alu_s;
                bus.rsp_valid <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
                ops_count     <= ops_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a
// transaction-level reference model; includes a FAIR=0 instance.
module tb_alu_arbiter;

    logic       clk;
    logic       reset_n;
    logic       busy;
    logic [7:0] ops_count;
    logic       busy_f;
    logic [7:0] ops_count_f;

    alu_arbiter_if #(.WIDTH(4)) bus ();
    alu_arbiter_if #(.WIDTH(4)) busf ();

    alu_arbiter #(.WIDTH(4), .FAIR(1), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .busy      (busy),
        .ops_count (ops_count)
    );

    alu_arbiter #(.WIDTH(4), .FAIR(0), .CNT_W(8)) dut_f (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (busf.slave),
        .busy      (busy_f),
        .ops_count (ops_count_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result of the ALU as {carry, result}, from plain arithmetic.
    function automatic logic [4:0] ref_alu(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [1:0] op,
                                           input logic l);
        int ia;
        int ib;
        int s;
        ia = {28'd0, a};
        ib = {28'd0, b};
        if (!l) begin
            case (op)
                2'b00:   s = 16 - ib;
                2'b01:   s = 16 - ia;
                2'b10:   s = ia + 16 - ib;
                default: s = ia + ib;
            endcase
        end else begin
            case (op)
                2'b00:   s = ia & ib;
                2'b01:   s = ia | ib;
                2'b10:   s = ia ^ ib;
                default: s = 15 - ia;
            endcase
        end
        return s[4:0];
    endfunction

    // ALU environment; drives carry/sign high on logic ops as garbage.
    logic [4:0] alu_res;
    logic [4:0] alu_res_f;
    always_comb begin
        alu_res   = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_l);
        bus.alu_r = alu_res[3:0];
        bus.alu_z = (alu_res[3:0] == 4'd0);
        bus.alu_c = bus.alu_l ? 1'b1 : alu_res[4];
        bus.alu_s = bus.alu_l ? 1'b1 : alu_res[3];
    end
    always_comb begin
        alu_res_f  = ref_alu(busf.alu_a, busf.alu_b, busf.alu_op, busf.alu_l);
        busf.alu_r = alu_res_f[3:0];
        busf.alu_z = (alu_res_f[3:0] == 4'd0);
        busf.alu_c = busf.alu_l ? 1'b1 : alu_res_f[4];
        busf.alu_s = busf.alu_l ? 1'b1 : alu_res_f[3];
    end

    // Reference model state
    bit         pend [2];
    logic [3:0] pa   [2];
    logic [3:0] pb   [2];
    logic [1:0] pop  [2];
    logic       pl   [2];
    bit         last_w;
    logic [7:0] cnt_m;

    task automatic set_req(input int i, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] op,
                           input logic l);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        pop[i]  = op;
        pl[i]   = l;
    endtask

    task automatic new_req(input int i);
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
            set_req(i, 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
        end
    endtask

    task automatic drive_reqs();
        bus.req0_valid = pend[0];
        bus.req0_a     = pa[0];
        bus.req0_b     = pb[0];
        bus.req0_op    = pop[0];
        bus.req0_l     = pl[0];
        bus.req1_valid = pend[1];
        bus.req1_a     = pa[1];
        bus.req1_b     = pb[1];
        bus.req1_op    = pop[1];
        bus.req1_l     = pl[1];
    endtask

    // One arbitration round starting at a negedge in IDLE.
    task automatic step(input int bp, input bit fresh);
        int         w;
        logic [4:0] res;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] er;
        logic [1:0] eop;
        logic       el;
        logic       ez;
        logic       ec;
        logic       es;
        if (fresh) begin
            new_req(0);
            new_req(1);
        end
        drive_reqs();
        #1;
        if (pend[0] && pend[1]) w = last_w ? 0 : 1;
        else if (pend[0])       w = 0;
        else if (pend[1])       w = 1;
        else                    w = -1;
        check("idle_ready0", 32'(bus.req0_ready), 32'(w == 0));
        check("idle_ready1", 32'(bus.req1_ready), 32'(w == 1));
        check("idle_busy", 32'(busy), 32'd0);
        if (w < 0) begin
            @(negedge clk);
        end else begin
            ea  = pa[w];
            eb  = pb[w];
            eop = pop[w];
            el  = pl[w];
            res = ref_alu(ea, eb, eop, el);
            er  = res[3:0];
            ez  = (er == 4'd0);
            ec  = el ? 1'b0 : res[4];
            es  = el ? 1'b0 : er[3];
            @(posedge clk);
            last_w  = w[0];
            pend[w] = 1'b0;
            @(negedge clk);
            if (fresh) new_req(w);
            drive_reqs();
            #1;
            check("exec_ready0", 32'(bus.req0_ready), 32'd0);
            check("exec_ready1", 32'(bus.req1_ready), 32'd0);
            check("exec_busy", 32'(busy), 32'd1);
            check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("exec_alu_a", 32'(bus.alu_a), 32'(ea));
            check("exec_alu_b", 32'(bus.alu_b), 32'(eb));
            check("exec_alu_op", 32'(bus.alu_op), 32'(eop));
            check("exec_alu_l", 32'(bus.alu_l), 32'(el));
            @(negedge clk);
            check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("rsp_id", 32'(bus.rsp_id), 32'(w));
            check("rsp_r", 32'(bus.rsp_r), 32'(er));
            check("rsp_z", 32'(bus.rsp_z), 32'(ez));
            check("rsp_c", 32'(bus.rsp_c), 32'(ec));
            check("rsp_s", 32'(bus.rsp_s), 32'(es));
            check("resp_ready0", 32'(bus.req0_ready), 32'd0);
            check("resp_ready1", 32'(bus.req1_ready), 32'd0);
            for (int k = 0; k < bp; k++) begin
                @(negedge clk);
                check("bp_valid", 32'(bus.rsp_valid), 32'd1);
                check("bp_r", 32'({bus.rsp_id, bus.rsp_r, bus.rsp_z,
                                   bus.rsp_c, bus.rsp_s}),
                      32'({w[0], er, ez, ec, es}));
                check("bp_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
                check("bp_busy", 32'(busy), 32'd1);
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            cnt_m = cnt_m + 8'd1;
            check("done_valid", 32'(bus.rsp_valid), 32'd0);
            check("done_count", 32'(ops_count), 32'(cnt_m));
            check("done_busy", 32'(busy), 32'd0);
            check("done_hold_r", 32'(bus.rsp_r), 32'(er));
        end
    endtask

    task automatic do_reset();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_reqs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(ops_count), 32'd0);
        check("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_l}), 32'd0);
        check("rst_rsp", 32'({bus.rsp_id, bus.rsp_r, bus.rsp_z,
                              bus.rsp_c, bus.rsp_s}), 32'd0);
        check("rst_f_valid", 32'(busf.rsp_valid), 32'd0);
        check("rst_f_count", 32'(ops_count_f), 32'd0);
        reset_n = 1'b1;
        last_w  = 1'b1;
        cnt_m   = 8'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n        = 1'b0;
        bus.rsp_ready  = 1'b0;
        busf.rsp_ready = 1'b0;
        busf.req0_valid = 1'b0;
        busf.req1_valid = 1'b0;
        busf.req0_a = 4'd0; busf.req0_b = 4'd0;
        busf.req0_op = 2'd0; busf.req0_l = 1'b0;
        busf.req1_a = 4'd0; busf.req1_b = 4'd0;
        busf.req1_op = 2'd0; busf.req1_l = 1'b0;
        for (int i = 0; i < 2; i++) set_req(i, 4'd0, 4'd0, 2'd0, 1'b0);
        do_reset();

        // Directed arithmetic and logic cases
        set_req(0, 4'b0011, 4'b0101, 2'b11, 1'b0);
        step(0, 1'b0);
        set_req(1, 4'b0101, 4'b0101, 2'b10, 1'b0);
        step(0, 1'b0);
        set_req(1, 4'b0110, 4'b0000, 2'b00, 1'b0);
        step(0, 1'b0);
        set_req(0, 4'b1100, 4'b1010, 2'b10, 1'b1);
        step(0, 1'b0);

        // Round-robin with both requesters continuously valid
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (!pend[j]) set_req(j, 4'($urandom), 4'($urandom),
                                      2'($urandom), 1'($urandom));
            end
            step(0, 1'b0);
        end
        check("rr_count", 32'(ops_count), 32'd4);

        // Back-pressure held for 3 cycles
        set_req(0, 4'b1001, 4'b0111, 2'b01, 1'b0);
        step(3, 1'b0);

        // Reset while in EXEC drops the operation
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        set_req(0, 4'h9, 4'h3, 2'b11, 1'b0);
        drive_reqs();
        #1;
        check("rx_grant0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rx_exec_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        set_req(1, 4'h2, 4'h1, 2'b11, 1'b0);
        drive_reqs();
        @(negedge clk);
        reset_n = 1'b1;
        last_w  = 1'b1;
        cnt_m   = 8'd0;
        check("rx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rx_count", 32'(ops_count), 32'd0);
        check("rx_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_l}), 32'd0);
        check("rx_busy", 32'(busy), 32'd0);
        step(0, 1'b0);

        // Randomized traffic; long enough to wrap ops_count
        for (int i = 0; i < 450; i++) begin
            step(int'($urandom_range(0, 2)), 1'b1);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_reqs();

        // Fixed priority instance: requester 0 always wins
        busf.req0_valid = 1'b1;
        busf.req1_valid = 1'b1;
        busf.req0_a  = 4'b0110;
        busf.req0_b  = 4'b0011;
        busf.req0_op = 2'b10;
        busf.req1_a  = 4'b0001;
        busf.req1_b  = 4'b0001;
        busf.req1_op = 2'b11;
        busf.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fp_ready0", 32'(busf.req0_ready), 32'd1);
            check("fp_ready1", 32'(busf.req1_ready), 32'd0);
            @(negedge clk);
            @(negedge clk);
            check("fp_rsp_valid", 32'(busf.rsp_valid), 32'd1);
            check("fp_rsp_id", 32'(busf.rsp_id), 32'd0);
            check("fp_rsp_r", 32'(busf.rsp_r), 32'd3);
            @(negedge clk);
        end
        check("fp_count", 32'(ops_count_f), 32'd4);
        busf.req0_valid = 1'b0;
        busf.req1_valid = 1'b0;
        busf.rsp_ready  = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
